keypoint_fetch: RTL and testbench
=================================

Name: keypoint_fetch

Overview:
- Downstream consumer of the two keypoint SRAMs filled by the detect/filter stage. Each entry is 19 bits: row[18:10], col[9:0].
- After detection completes, the block reads both SRAMs in order: layer 0 first, then layer 1.
- It drops keypoints too close to the image edge for a descriptor window.
- Surviving keypoints stream to the descriptor stage over a valid/ready handshake, buffered in a small FIFO so SRAM read latency and backpressure never lose data.

Parameters:
IMG_ROWS, 480, image height in rows
IMG_COLS, 640, image width in columns
BORDER, 8, minimum distance from any edge for a kept keypoint
FIFO_DEPTH, 4, output FIFO entries (power of two, >=2)

Ports:
clk  in  1  system clock
rst  in  1  reset, synchronous, active-high
start  in  1  one-cycle pulse to begin a pass; ignored unless idle
kp1_count  in  12  entries valid in keypoint SRAM 1 (0..2048)
kp2_count  in  12  entries valid in keypoint SRAM 2 (0..2048)
kp1_addr  out  11  read address, keypoint SRAM 1
kp1_dout  in  19  read data, keypoint SRAM 1
kp2_addr  out  11  read address, keypoint SRAM 2
kp2_dout  in  19  read data, keypoint SRAM 2
kp_valid  out  1  output keypoint valid
kp_ready  in  1  downstream accept
kp_row  out  9  keypoint row
kp_col  out  10  keypoint column
kp_layer  out  1  0 = SRAM 1 (scale 0), 1 = SRAM 2
busy  out  1  high from the cycle after an accepted start until done
done  out  1  one-cycle pulse when the pass completes
dropped_count  out  12  keypoints rejected by the border filter this pass

Behaviour:
- Clock, reset and retention
  - One clock: clk. Reset rst is synchronous and active-high.
  - Reset values: kp1_addr=0, kp2_addr=0, kp_valid=0, kp_row=0, kp_col=0, kp_layer=0, busy=0, done=0, dropped_count=0. FIFO is emptied, in-flight reads are discarded, state=IDLE.
  - Reset mid-pass aborts silently: no done pulse.
- SRAM read
  - Address presented in cycle t gives dout in cycle t+1.
  - Only one SRAM is read in any cycle.
- FSM states: IDLE, RD1, RD2, DRAIN, FIN.
  - IDLE: on start, latch both counts (values >2048 clamp to 2048), clear issue index and dropped_count, go to RD1.
  - RD1: while issued < cnt1 and credit is available, drive kp1_addr=index, increment index, mark the read in flight. When issued==cnt1, reset index to 0 and go to RD2.
  - RD2: same as RD1 on SRAM 2; when finished go to DRAIN.
  - DRAIN: wait until no read is in flight and the FIFO is empty, then go to FIN.
  - FIN: done=1 for this cycle only, then go to IDLE.
- Credit rule: a read is issued only if fifo_count + inflight < FIFO_DEPTH. Reads issue back-to-back at 1 per cycle when kp_ready is held high.
- Returned data, one cycle after issue: split into row/col and apply the filter.
  - Keep iff BORDER <= row <= IMG_ROWS-1-BORDER and BORDER <= col <= IMG_COLS-1-BORDER.
  - Kept entries are pushed into the FIFO with a layer tag.
  - Dropped entries increment dropped_count, saturating at 4095. dropped_count holds its value after done until the next start.
- Output
  - kp_valid = FIFO non-empty; {kp_layer, kp_row, kp_col} = FIFO head.
  - Pop when kp_valid && kp_ready.
  - Head is stable while kp_valid && !kp_ready.
  - A simultaneous push and pop is allowed in the same cycle; the credit rule guarantees the FIFO never overflows.
- Ordering: outputs follow SRAM address order, with all layer-0 entries before any layer-1 entry.
- busy = state != IDLE.
- Zero counts: start at cycle 0 gives RD1 at 1, RD2 at 2, DRAIN at 3, FIN at 4 (done=1 at cycle 4). No kp_valid is asserted.
- kpN_addr holds its last driven value when not reading.

Test Plan:
- Reset then start with kp1_count=0, kp2_count=0 -> done pulses exactly 4 cycles after start; kp_valid never 1; dropped_count=0.
- kp1_count=3, SRAM1={(100,200),(5,300),(240,632)}, kp2_count=1, SRAM2={(50,50)}, kp_ready=1 -> outputs in order (100,200,L0) then (50,50,L1); dropped_count=2; done once.
- kp1_count=8, all entries in-border, kp_ready held 0 for 20 cycles then 1 -> at most FIFO_DEPTH reads issued before the first pop; all 8 delivered in address order with no loss or duplication; head stable while stalled.
- Boundary filter: entries (8,8), (471,631), (7,320), (240,632) -> first two kept, last two dropped.
- Assert rst for 1 cycle mid-RD1 after 2 outputs -> next cycle kp_valid=0, busy=0, addresses 0, no done pulse. A new start then replays the pass from address 0.
- start pulsed while busy, and kp1_count=3000 -> the extra start is ignored; count clamps to 2048, reading addresses 0..2047 exactly once.

Source files
------------

// File: rtl/keypoint_fetch.sv
// keypoint_fetch: reads both keypoint SRAMs in order, drops border keypoints, streams survivors via a FIFO
module keypoint_fetch #(
   parameter int IMG_ROWS   = 480,
   parameter int IMG_COLS   = 640,
   parameter int BORDER     = 8,
   parameter int FIFO_DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [11:0] kp1_count,
   input  logic [11:0] kp2_count,
   output logic [10:0] kp1_addr,
   input  logic [18:0] kp1_dout,
   output logic [10:0] kp2_addr,
   input  logic [18:0] kp2_dout,
   output logic        kp_valid,
   input  logic        kp_ready,
   output logic [8:0]  kp_row,
   output logic [9:0]  kp_col,
   output logic        kp_layer,
   output logic        busy,
   output logic        done,
   output logic [11:0] dropped_count
);
   localparam int PW = $clog2(FIFO_DEPTH);
   typedef enum logic [2:0] {IDLE, RD1, RD2, DRAIN, FIN} state_t;
   state_t state, state_nxt;
   logic [11:0] cnt1, cnt2, idx;
   logic [10:0] addr1_q, addr2_q;
   logic inflight, inflight_layer;
   logic [19:0] mem [FIFO_DEPTH];
   logic [19:0] head;
   logic [PW-1:0] wr_ptr, rd_ptr;
   logic [PW:0] fifo_count;
   logic credit, issue1, issue2, push, pop, keep;
   logic [18:0] rdata;
   logic [8:0] r_row;
   logic [9:0] r_col;

   // The address is driven combinationally in the issue cycle so the SRAM returns data the next cycle
   assign kp1_addr = issue1 ? idx[10:0] : addr1_q;
   assign kp2_addr = issue2 ? idx[10:0] : addr2_q;
   assign credit = int'(fifo_count) + int'(inflight) < FIFO_DEPTH;
   assign rdata = inflight_layer ? kp2_dout : kp1_dout;
   assign r_row = rdata[18:10];
   assign r_col = rdata[9:0];
   assign keep = int'(r_row) >= BORDER && int'(r_row) <= IMG_ROWS - 1 - BORDER &&
                 int'(r_col) >= BORDER && int'(r_col) <= IMG_COLS - 1 - BORDER;
   assign push = inflight && keep;
   assign pop = kp_valid && kp_ready;
   assign head = mem[rd_ptr];
   assign kp_valid = fifo_count != '0;
   assign kp_layer = kp_valid & head[19];
   assign kp_row = kp_valid ? head[18:10] : '0;
   assign kp_col = kp_valid ? head[9:0] : '0;
   assign busy = state != IDLE;
   assign done = state == FIN;

   // State register
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else state <= state_nxt;
   end

   // Next state and read issue; a layer ends once every entry has been issued
   always_comb begin
      state_nxt = state;
      issue1 = 1'b0;
      issue2 = 1'b0;
      case (state)
         IDLE:    if (start) state_nxt = RD1;
         RD1:     if (idx == cnt1) state_nxt = RD2; else issue1 = credit;
         RD2:     if (idx == cnt2) state_nxt = DRAIN; else issue2 = credit;
         DRAIN:   if (!inflight && fifo_count == '0) state_nxt = FIN;
         FIN:     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Pass bookkeeping: counts, issue index, held addresses, in-flight tracking, drop counter
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt1 <= '0;
         cnt2 <= '0;
         idx <= '0;
         addr1_q <= '0;
         addr2_q <= '0;
         inflight <= 1'b0;
         inflight_layer <= 1'b0;
         dropped_count <= '0;
      end else begin
         inflight <= issue1 || issue2;
         inflight_layer <= issue2;
         if (issue1) addr1_q <= idx[10:0];
         if (issue2) addr2_q <= idx[10:0];
         if (issue1 || issue2) idx <= idx + 12'd1;
         else if (state == RD1 && idx == cnt1) idx <= '0;
         if (inflight && !keep && dropped_count != 12'hfff) dropped_count <= dropped_count + 12'd1;
         if (state == IDLE && start) begin
            cnt1 <= kp1_count > 12'd2048 ? 12'd2048 : kp1_count;
            cnt2 <= kp2_count > 12'd2048 ? 12'd2048 : kp2_count;
            idx <= '0;
            dropped_count <= '0;
         end
      end
   end

   // FIFO pointers and occupancy; credit gating keeps pushes from overflowing
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         fifo_count <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PW'(1);
         if (pop) rd_ptr <= rd_ptr + PW'(1);
         fifo_count <= fifo_count + (PW + 1)'(push) - (PW + 1)'(pop);
      end
   end

   // FIFO storage tagged with the source layer
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= {inflight_layer, rdata};
   end
endmodule

// File: tb/tb_keypoint_fetch.sv
// tb_keypoint_fetch: directed scoreboard bench for keypoint_fetch
module tb_keypoint_fetch;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [11:0] kp1_count = '0;
   logic [11:0] kp2_count = '0;
   logic [10:0] kp1_addr, kp2_addr;
   logic [18:0] kp1_dout = '0;
   logic [18:0] kp2_dout = '0;
   logic        kp_valid;
   logic        kp_ready = 1'b1;
   logic [8:0]  kp_row;
   logic [9:0]  kp_col;
   logic        kp_layer;
   logic        busy, done;
   logic [11:0] dropped_count;

   logic [18:0] sram1 [2048];
   logic [18:0] sram2 [2048];
   logic [19:0] exp_q [$];
   int checks = 0;
   int errors = 0;
   int done_cnt = 0;
   int pops = 0;
   int max_a1 = 0;
   bit valid_seen = 0;
   bit stall_prev = 0;
   logic [19:0] head_prev = '0;
   int n;

   keypoint_fetch dut (
      .clk(clk), .rst(rst), .start(start),
      .kp1_count(kp1_count), .kp2_count(kp2_count),
      .kp1_addr(kp1_addr), .kp1_dout(kp1_dout),
      .kp2_addr(kp2_addr), .kp2_dout(kp2_dout),
      .kp_valid(kp_valid), .kp_ready(kp_ready),
      .kp_row(kp_row), .kp_col(kp_col), .kp_layer(kp_layer),
      .busy(busy), .done(done), .dropped_count(dropped_count)
   );

   always #5 clk = ~clk;

   // Synchronous-read SRAM models: address seen at an edge, data valid the following cycle
   always @(posedge clk) begin
      kp1_dout <= sram1[kp1_addr];
      kp2_dout <= sram2[kp2_addr];
      if (int'(kp1_addr) > max_a1) max_a1 = int'(kp1_addr);
   end

   function automatic void check(input string name, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, expv);
      end
   endfunction

   function automatic logic [18:0] kp(input int r, input int c);
      return {9'(r), 10'(c)};
   endfunction

   // Monitor: compares every accepted output against the scoreboard queue
   always @(negedge clk) begin
      if (rst) stall_prev = 0;
      else begin
         if (kp_valid) valid_seen = 1;
         if (done) done_cnt++;
         if (stall_prev && kp_valid) check("head_stable", {12'd0, kp_layer, kp_row, kp_col}, {12'd0, head_prev});
         stall_prev = kp_valid && !kp_ready;
         head_prev = {kp_layer, kp_row, kp_col};
         if (kp_valid && kp_ready) begin
            pops++;
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_output: got %h expected none", {kp_layer, kp_row, kp_col});
            end else check("kp_out", {12'd0, kp_layer, kp_row, kp_col}, {12'd0, exp_q.pop_front()});
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1;
      tick();
      tick();
      rst = 0;
      exp_q.delete();
      max_a1 = 0;
   endtask

   task automatic start_pass(input logic [11:0] c1, input logic [11:0] c2);
      kp1_count = c1;
      kp2_count = c2;
      done_cnt = 0;
      pops = 0;
      valid_seen = 0;
      start = 1;
      tick();
      start = 0;
   endtask

   task automatic wait_done(input int limit, output int cyc);
      cyc = 1;
      while (!done && cyc < limit) begin
         tick();
         cyc++;
      end
      if (!done) begin
         checks++;
         errors++;
         $display("FAIL done_timeout: got no done after %0d cycles expected done", cyc);
      end
      tick();
   endtask

   task automatic end_checks(input int drops);
      check("done_once", done_cnt, 1);
      check("done_single_cycle", {31'd0, done}, 0);
      check("dropped_count", {20'd0, dropped_count}, drops);
      check("queue_empty", exp_q.size(), 0);
      check("idle_after_done", {31'd0, busy}, 0);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset state
      do_reset();
      check("rst_kp_valid", {31'd0, kp_valid}, 0);
      check("rst_kp_row", {23'd0, kp_row}, 0);
      check("rst_kp_col", {22'd0, kp_col}, 0);
      check("rst_kp_layer", {31'd0, kp_layer}, 0);
      check("rst_busy", {31'd0, busy}, 0);
      check("rst_done", {31'd0, done}, 0);
      check("rst_dropped", {20'd0, dropped_count}, 0);
      check("rst_addr1", {21'd0, kp1_addr}, 0);
      check("rst_addr2", {21'd0, kp2_addr}, 0);

      // Zero counts: done exactly 4 cycles after start
      start_pass(12'd0, 12'd0);
      check("busy_after_start", {31'd0, busy}, 1);
      wait_done(20, n);
      check("zero_done_latency", n, 4);
      check("zero_no_valid", {31'd0, valid_seen}, 0);
      end_checks(0);

      // Mixed pass: two layer-0 entries out of border
      sram1[0] = kp(100, 200); sram1[1] = kp(5, 300); sram1[2] = kp(240, 632);
      sram2[0] = kp(50, 50);
      exp_q.push_back({1'b0, kp(100, 200)});
      exp_q.push_back({1'b1, kp(50, 50)});
      kp_ready = 1;
      start_pass(12'd3, 12'd1);
      wait_done(100, n);
      end_checks(2);

      // Boundary filter on both layers
      sram1[0] = kp(8, 8); sram1[1] = kp(471, 631); sram1[2] = kp(7, 320); sram1[3] = kp(240, 632);
      sram2[0] = kp(471, 8); sram2[1] = kp(9, 633);
      exp_q.push_back({1'b0, kp(8, 8)});
      exp_q.push_back({1'b0, kp(471, 631)});
      exp_q.push_back({1'b1, kp(471, 8)});
      start_pass(12'd4, 12'd2);
      wait_done(100, n);
      end_checks(3);

      // Backpressure: at most FIFO_DEPTH reads before the first pop
      do_reset();
      for (int i = 0; i < 8; i++) sram1[i] = kp(20 + i, 30 + 3 * i);
      for (int i = 0; i < 8; i++) exp_q.push_back({1'b0, kp(20 + i, 30 + 3 * i)});
      kp_ready = 0;
      start_pass(12'd8, 12'd0);
      for (int i = 0; i < 20; i++) tick();
      check("stall_max_addr", max_a1, 3);
      check("stall_valid", {31'd0, kp_valid}, 1);
      check("stall_head", {12'd0, kp_layer, kp_row, kp_col}, {13'd0, kp(20, 30)});
      kp_ready = 1;
      wait_done(100, n);
      end_checks(0);
      check("stall_all_out", pops, 8);

      // Reset mid-RD1 after two outputs, then replay
      for (int i = 0; i < 8; i++) exp_q.push_back({1'b0, kp(20 + i, 30 + 3 * i)});
      start_pass(12'd8, 12'd0);
      for (int i = 0; i < 50 && pops < 2; i++) tick();
      check("abort_two_out", pops, 2);
      rst = 1;
      tick();
      rst = 0;
      exp_q.delete();
      check("abort_valid", {31'd0, kp_valid}, 0);
      check("abort_busy", {31'd0, busy}, 0);
      check("abort_addr1", {21'd0, kp1_addr}, 0);
      check("abort_addr2", {21'd0, kp2_addr}, 0);
      done_cnt = 0;
      for (int i = 0; i < 10; i++) tick();
      check("abort_no_done", done_cnt, 0);
      for (int i = 0; i < 8; i++) exp_q.push_back({1'b0, kp(20 + i, 30 + 3 * i)});
      start_pass(12'd8, 12'd0);
      wait_done(100, n);
      end_checks(0);
      check("replay_all_out", pops, 8);

      // Clamp to 2048 and ignore start while busy
      do_reset();
      for (int i = 0; i < 2048; i++) begin
         sram1[i] = kp(8 + (i >> 3), 8 + (i & 7) * 70);
         exp_q.push_back({1'b0, kp(8 + (i >> 3), 8 + (i & 7) * 70)});
      end
      start_pass(12'd3000, 12'd0);
      for (int i = 0; i < 5; i++) tick();
      start = 1;
      tick();
      start = 0;
      wait_done(6000, n);
      end_checks(0);
      check("clamp_all_out", pops, 2048);
      check("clamp_max_addr", max_a1, 2047);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
